// File: rtl/lfsr_checker.sv
// LFSR sequence checker: self-seeding XNOR predictor, lock/loss FSM, error stats.
// Define LFSR_CHECKER_WORD_COUNT_EN to build the locked-word counter.
module lfsr_checker #(
  parameter int NUM_BITS   = 16,
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  input  logic                i_Data_Valid,
  input  logic [NUM_BITS-1:0] i_Data,
  input  logic                i_Clear_Counts,
  output logic                o_Locked,
  output logic                o_Error,
  output logic [31:0]         o_Error_Count,
  output logic [31:0]         o_Word_Count,
  output logic                o_Lock_Lost
);

  function automatic logic [31:0] tap_mask(input int n);
    logic [31:0] m;
    m = '0;
    case (n)
      3:       m = 32'h0000_0006;
      4:       m = 32'h0000_000C;
      5:       m = 32'h0000_0014;
      6:       m = 32'h0000_0030;
      7:       m = 32'h0000_0060;
      8:       m = 32'h0000_00B8;
      9:       m = 32'h0000_0110;
      10:      m = 32'h0000_0240;
      11:      m = 32'h0000_0500;
      12:      m = 32'h0000_0829;
      13:      m = 32'h0000_100D;
      14:      m = 32'h0000_2015;
      15:      m = 32'h0000_6000;
      16:      m = 32'h0000_D008;
      17:      m = 32'h0001_2000;
      18:      m = 32'h0002_0400;
      19:      m = 32'h0004_0023;
      20:      m = 32'h0009_0000;
      21:      m = 32'h0014_0000;
      22:      m = 32'h0030_0000;
      23:      m = 32'h0042_0000;
      24:      m = 32'h00E1_0000;
      25:      m = 32'h0120_0000;
      26:      m = 32'h0200_0023;
      27:      m = 32'h0400_0013;
      28:      m = 32'h0900_0000;
      29:      m = 32'h1400_0000;
      30:      m = 32'h2000_0029;
      31:      m = 32'h4800_0000;
      32:      m = 32'h8020_0003;
      default: m = '0;
    endcase
    return m;
  endfunction

  localparam logic [31:0]         TAPS_W    = tap_mask(NUM_BITS);
  localparam logic [NUM_BITS-1:0] TAPS      = TAPS_W[NUM_BITS-1:0];
  localparam logic [NUM_BITS-1:0] ONES      = '1;
  localparam logic [7:0]          LOCK_LAST = 8'(LOCK_COUNT - 1);
  localparam logic [7:0]          LOSS_LAST = 8'(LOSS_COUNT - 1);

  // Taps come in pairs, so a chained XNOR reduces to inverted parity.
  function automatic logic [NUM_BITS-1:0] lfsr_next(
    input logic [NUM_BITS-1:0] s
  );
    return {s[NUM_BITS-2:0], ~^(s & TAPS)};
  endfunction

  typedef enum logic {
    SEARCH,
    LOCKED
  } state_t;

  state_t              state;
  logic [NUM_BITS-1:0] pred;
  logic                seeded;
  logic [7:0]          match_cnt;
  logic [7:0]          miss_cnt;

  logic                word_ok;
  logic                seed_hit;
  logic                miss;
  logic                lose;
  logic [NUM_BITS-1:0] next_data;
  logic [NUM_BITS-1:0] next_pred;

  assign word_ok   = (i_Data == pred);
  // The first word after reset only seeds; all-ones is the XNOR lock-up word.
  assign seed_hit  = seeded && word_ok && (i_Data != ONES);
  assign miss      = i_Data_Valid && (state == LOCKED) && !word_ok;
  assign lose      = miss && (miss_cnt == LOSS_LAST);
  assign next_data = lfsr_next(i_Data);
  assign next_pred = lfsr_next(pred);

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state     <= SEARCH;
      pred      <= '0;
      seeded    <= 1'b0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      o_Locked  <= 1'b0;
      o_Error   <= 1'b0;
    end else begin
      o_Error <= miss;
      if (i_Data_Valid) begin
        unique case (state)
          SEARCH: begin
            pred   <= next_data;
            seeded <= 1'b1;
            if (!seed_hit) begin
              match_cnt <= '0;
            end else if (match_cnt == LOCK_LAST) begin
              state     <= LOCKED;
              o_Locked  <= 1'b1;
              match_cnt <= '0;
              miss_cnt  <= '0;
            end else begin
              match_cnt <= match_cnt + 8'd1;
            end
          end
          LOCKED: begin
            if (lose) begin
              state     <= SEARCH;
              o_Locked  <= 1'b0;
              pred      <= next_data;
              match_cnt <= '0;
              miss_cnt  <= '0;
            end else begin
              pred     <= next_pred;
              miss_cnt <= miss ? miss_cnt + 8'd1 : '0;
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      o_Error_Count <= '0;
      o_Lock_Lost   <= 1'b0;
    end else if (i_Clear_Counts) begin
      o_Error_Count <= '0;
      o_Lock_Lost   <= 1'b0;
    end else begin
      if (miss && (o_Error_Count != '1))
        o_Error_Count <= o_Error_Count + 32'd1;
      if (lose)
        o_Lock_Lost <= 1'b1;
    end
  end

`ifdef LFSR_CHECKER_WORD_COUNT_EN
  logic word_inc;
  assign word_inc = i_Data_Valid && (state == LOCKED);

  always_ff @(posedge i_Clk) begin
    if (i_Rst || i_Clear_Counts)
      o_Word_Count <= '0;
    else if (word_inc && (o_Word_Count != '1))
      o_Word_Count <= o_Word_Count + 32'd1;
  end
`else
  assign o_Word_Count = '0;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker (16-bit, lock 4, loss 3).
// Behavioural model pushes expectations; a posedge monitor pops and compares.
module tb_lfsr_checker;

  localparam int LOCK_N = 4;
  localparam int LOSS_N = 3;
`ifdef LFSR_CHECKER_WORD_COUNT_EN
  localparam bit WC_EN = 1'b1;
`else
  localparam bit WC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        i_Rst = 1'b0;
  logic        i_Data_Valid = 1'b0;
  logic [15:0] i_Data = '0;
  logic        i_Clear_Counts = 1'b0;
  logic        o_Locked;
  logic        o_Error;
  logic [31:0] o_Error_Count;
  logic [31:0] o_Word_Count;
  logic        o_Lock_Lost;

  lfsr_checker #(
    .NUM_BITS(16),
    .LOCK_COUNT(LOCK_N),
    .LOSS_COUNT(LOSS_N)
  ) dut (
    .i_Clk(clk),
    .i_Rst(i_Rst),
    .i_Data_Valid(i_Data_Valid),
    .i_Data(i_Data),
    .i_Clear_Counts(i_Clear_Counts),
    .o_Locked(o_Locked),
    .o_Error(o_Error),
    .o_Error_Count(o_Error_Count),
    .o_Word_Count(o_Word_Count),
    .o_Lock_Lost(o_Lock_Lost)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        locked;
    logic        err;
    logic        lost;
    logic [31:0] ecnt;
    logic [31:0] wcnt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic        m_locked = 0;
  logic        m_seeded = 0;
  logic        m_err = 0;
  logic        m_lost = 0;
  logic [15:0] m_pred = 0;
  int          m_match = 0;
  int          m_miss = 0;
  logic [31:0] m_ecnt = 0;
  logic [31:0] m_wcnt = 0;
  logic [15:0] g;

  // taps 16,15,13,4 (1-based) -> bits 15,14,12,3
  function automatic logic [15:0] nxt(input logic [15:0] s);
    return {s[14:0], ~(s[15] ^ s[14] ^ s[12] ^ s[3])};
  endfunction

  task automatic step(input logic rst, input logic v,
                      input logic [15:0] d, input logic clr);
    exp_t e;
    logic hit;
    @(negedge clk);
    i_Rst = rst;
    i_Data_Valid = v;
    i_Data = d;
    i_Clear_Counts = clr;
    if (rst) begin
      m_locked = 0; m_seeded = 0; m_err = 0; m_lost = 0;
      m_pred = 0; m_match = 0; m_miss = 0; m_ecnt = 0; m_wcnt = 0;
    end else begin
      m_err = 0;
      if (v) begin
        if (!m_locked) begin
          hit = m_seeded && (d == m_pred) && (d != 16'hFFFF);
          m_match = hit ? m_match + 1 : 0;
          if (m_match == LOCK_N) begin
            m_locked = 1; m_match = 0; m_miss = 0;
          end
          m_pred = nxt(d);
          m_seeded = 1;
        end else begin
          if (m_wcnt != 32'hFFFF_FFFF) m_wcnt = m_wcnt + 1;
          if (d != m_pred) begin
            m_err = 1;
            if (m_ecnt != 32'hFFFF_FFFF) m_ecnt = m_ecnt + 1;
            m_miss = m_miss + 1;
            if (m_miss == LOSS_N) begin
              m_locked = 0; m_lost = 1; m_match = 0; m_miss = 0;
              m_pred = nxt(d);
            end else begin
              m_pred = nxt(m_pred);
            end
          end else begin
            m_miss = 0;
            m_pred = nxt(m_pred);
          end
        end
      end
      if (clr) begin
        m_ecnt = 0; m_wcnt = 0; m_lost = 0;
      end
    end
    e.locked = m_locked;
    e.err = m_err;
    e.lost = m_lost;
    e.ecnt = m_ecnt;
    e.wcnt = WC_EN ? m_wcnt : 32'd0;
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      n_cmp = n_cmp + 5;
      if (o_Locked !== mon_e.locked) begin
        n_bad++;
        $display("FAIL sb_locked got %0b want %0b t=%0t", o_Locked, mon_e.locked, $time);
      end
      if (o_Error !== mon_e.err) begin
        n_bad++;
        $display("FAIL sb_error got %0b want %0b t=%0t", o_Error, mon_e.err, $time);
      end
      if (o_Lock_Lost !== mon_e.lost) begin
        n_bad++;
        $display("FAIL sb_lost got %0b want %0b t=%0t", o_Lock_Lost, mon_e.lost, $time);
      end
      if (o_Error_Count !== mon_e.ecnt) begin
        n_bad++;
        $display("FAIL sb_ecnt got %h want %h t=%0t", o_Error_Count, mon_e.ecnt, $time);
      end
      if (o_Word_Count !== mon_e.wcnt) begin
        n_bad++;
        $display("FAIL sb_wcnt got %h want %h t=%0t", o_Word_Count, mon_e.wcnt, $time);
      end
    end
  end

  task automatic test_reset();
    step(1, 1, 16'h1234, 1);
    step(1, 0, 16'h0000, 0);
    n_cmp++;
    if ({o_Locked, o_Error, o_Lock_Lost} !== 3'b000 || o_Error_Count !== 32'd0
        || o_Word_Count !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_state got %b/%h/%h want 000/0/0",
               {o_Locked, o_Error, o_Lock_Lost}, o_Error_Count, o_Word_Count);
    end
  endtask

  task automatic test_lock();
    g = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      step(0, 1, g, 0);
      g = nxt(g);
      if (i >= 3) begin
        n_cmp++;
        if (o_Locked !== (i == 4)) begin
          n_bad++;
          $display("FAIL lock_word%0d got %0b want %0b", i + 1, o_Locked, i == 4);
        end
      end
    end
    n_cmp++;
    if (o_Error_Count !== 32'd0) begin
      n_bad++;
      $display("FAIL lock_ecnt got %h want 0", o_Error_Count);
    end
  endtask

  task automatic test_single_error();
    step(0, 1, g, 0);
    g = nxt(g);
    step(0, 1, g ^ 16'h0001, 0);
    g = nxt(g);
    n_cmp++;
    if (o_Error !== 1'b1 || o_Error_Count !== 32'd1 || o_Locked !== 1'b1) begin
      n_bad++;
      $display("FAIL single_err got err=%0b cnt=%h lk=%0b want 1/1/1",
               o_Error, o_Error_Count, o_Locked);
    end
    step(0, 1, g, 0);
    g = nxt(g);
    n_cmp++;
    if (o_Error !== 1'b0 || o_Locked !== 1'b1) begin
      n_bad++;
      $display("FAIL single_next got err=%0b lk=%0b want 0/1", o_Error, o_Locked);
    end
    n_cmp++;
    if (o_Word_Count !== (WC_EN ? 32'd3 : 32'd0)) begin
      n_bad++;
      $display("FAIL word_count got %h want %h", o_Word_Count, WC_EN ? 32'd3 : 32'd0);
    end
  endtask

  task automatic test_loss_relock();
    step(0, 1, g, 1);
    g = nxt(g);
    n_cmp++;
    if (o_Error_Count !== 32'd0 || o_Locked !== 1'b1) begin
      n_bad++;
      $display("FAIL clear_keeps_lock got cnt=%h lk=%0b want 0/1", o_Error_Count, o_Locked);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 1, g ^ 16'h0001, 0);
      g = nxt(g);
      n_cmp++;
      if (o_Locked !== (i < 2)) begin
        n_bad++;
        $display("FAIL loss_bad%0d got lk=%0b want %0b", i + 1, o_Locked, i < 2);
      end
    end
    n_cmp++;
    if (o_Lock_Lost !== 1'b1 || o_Error_Count !== 32'd3) begin
      n_bad++;
      $display("FAIL loss_flags got lost=%0b cnt=%h want 1/3", o_Lock_Lost, o_Error_Count);
    end
    for (int i = 0; i < 5; i++) begin
      step(0, 1, g, 0);
      g = nxt(g);
      if (i >= 3) begin
        n_cmp++;
        if (o_Locked !== (i == 4)) begin
          n_bad++;
          $display("FAIL relock_word%0d got %0b want %0b", i + 1, o_Locked, i == 4);
        end
      end
    end
  endtask

  task automatic test_gap();
    step(1, 0, 16'h0000, 0);
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 16'hFFFF, 0);
      n_cmp++;
      if (o_Locked !== 1'b0) begin
        n_bad++;
        $display("FAIL all_ones%0d got lk=%0b want 0", i, o_Locked);
      end
    end
    g = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      step(0, 1, g, 0);
      g = nxt(g);
      for (int k = 0; k < 2; k++) begin
        step(0, 0, 16'($urandom), 0);
        n_cmp++;
        if (o_Locked !== (i == 4)) begin
          n_bad++;
          $display("FAIL gap_word%0d got lk=%0b want %0b", i + 1, o_Locked, i == 4);
        end
      end
    end
  endtask

  task automatic test_saturate();
    force dut.o_Error_Count = 32'hFFFF_FFFF;
    #1;
    release dut.o_Error_Count;
    m_ecnt = 32'hFFFF_FFFF;
    step(0, 1, g ^ 16'h0001, 0);
    g = nxt(g);
    n_cmp++;
    if (o_Error_Count !== 32'hFFFF_FFFF || o_Error !== 1'b1) begin
      n_bad++;
      $display("FAIL saturate got cnt=%h err=%0b want ffffffff/1", o_Error_Count, o_Error);
    end
    step(0, 1, g, 0);
    g = nxt(g);
  endtask

  task automatic test_clear_on_error();
    step(0, 1, g ^ 16'h0001, 1);
    g = nxt(g);
    n_cmp++;
    if (o_Error_Count !== 32'd0 || o_Error !== 1'b1 || o_Locked !== 1'b1) begin
      n_bad++;
      $display("FAIL clear_wins got cnt=%h err=%0b lk=%0b want 0/1/1",
               o_Error_Count, o_Error, o_Locked);
    end
    step(0, 1, g, 0);
    g = nxt(g);
  endtask

  task automatic test_reset_locked();
    step(0, 1, g ^ 16'h0001, 0);
    g = nxt(g);
    n_cmp++;
    if (o_Locked !== 1'b1 || o_Error_Count !== 32'd1) begin
      n_bad++;
      $display("FAIL pre_reset got lk=%0b cnt=%h want 1/1", o_Locked, o_Error_Count);
    end
    step(1, 1, g ^ 16'h0001, 0);
    n_cmp++;
    if ({o_Locked, o_Error, o_Lock_Lost} !== 3'b000 || o_Error_Count !== 32'd0
        || o_Word_Count !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_locked got %b/%h/%h want 000/0/0",
               {o_Locked, o_Error, o_Lock_Lost}, o_Error_Count, o_Word_Count);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_lock();
    test_single_error();
    test_loss_relock();
    test_gap();
    test_saturate();
    test_clear_on_error();
    test_reset_locked();
    step(0, 0, 16'h0000, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lfsr_checker.md
LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 The block SHALL have parameter NUM_BITS, default 16, giving the LFSR word width (legal range 3..32).
REQ-002 The block SHALL have parameter LOCK_COUNT, default 4, giving the consecutive correct predictions needed to declare lock (range 1..255).
REQ-003 The block SHALL have parameter LOSS_COUNT, default 3, giving the consecutive mismatches while locked needed to drop lock (range 1..255).
REQ-004 i_Clk  input  1  single clock; all logic on its rising edge.
REQ-005 i_Rst  input  1  reset, synchronous and active-high.
REQ-006 i_Data_Valid  input  1  i_Data is a new LFSR word this cycle.
REQ-007 i_Data  input  NUM_BITS  received LFSR word.
REQ-008 i_Clear_Counts  input  1  synchronous clear of the error and word counters.
REQ-009 o_Locked  output  1  predictor is synchronised to the incoming sequence.
REQ-010 o_Error  output  1  one-cycle pulse: the previous valid word mismatched while locked.
REQ-011 o_Error_Count  output  32  saturating count of mismatches while locked.
REQ-012 o_Word_Count  output  32  saturating count of valid words checked while locked.
REQ-013 o_Lock_Lost  output  1  sticky flag: lock was lost since the last clear.

Function
REQ-014 The next-state function SHALL be next(s) = {s[NUM_BITS-1:1], x}, where x is the XNOR of the XAPP052 taps for NUM_BITS (e.g. 16: bits 16,15,13,4; 8: bits 8,6,5,4; 5: bits 5,3), bit 1 being the LSB.
REQ-015 The FSM SHALL have states SEARCH and LOCKED, and SHALL update only on cycles with i_Data_Valid=1.
REQ-016 In SEARCH, a valid word equal to the held prediction SHALL increment the match counter; otherwise the match counter SHALL be cleared to 0.
REQ-017 In SEARCH, the prediction SHALL be reloaded with next(i_Data) on every valid word (self-seeding).
REQ-018 An all-ones i_Data (the XNOR lock-up state) SHALL never count as a match and SHALL clear the match counter.
REQ-019 When the match counter reaches LOCK_COUNT, the FSM SHALL enter LOCKED on that same edge, and o_Locked SHALL be 1 from the next cycle.
REQ-020 In LOCKED, the prediction SHALL advance as next(prediction), ignoring i_Data, so that single-word errors do not propagate.
REQ-021 In LOCKED, a mismatch SHALL:
- assert o_Error for exactly one cycle, on the cycle after the word;
- increment o_Error_Count;
- increment the miss counter.
REQ-022 In LOCKED, a match SHALL clear the miss counter.
REQ-023 In LOCKED, o_Word_Count SHALL increment on every valid word.
REQ-024 When the miss counter reaches LOSS_COUNT, the FSM SHALL:
- return to SEARCH;
- set o_Lock_Lost;
- clear the match and miss counters;
- reload the prediction with next(i_Data).
REQ-025 o_Error_Count and o_Word_Count SHALL saturate at 0xFFFFFFFF and never wrap.
REQ-026 When i_Clear_Counts=1, o_Error_Count, o_Word_Count and o_Lock_Lost SHALL go to 0 on that edge, and the clear SHALL win over a same-cycle increment.
REQ-027 i_Clear_Counts SHALL NOT affect the FSM state, the prediction, or o_Locked.
REQ-028 Gaps in i_Data_Valid of any length SHALL be tolerated, with all state holding during the gap.

Reset
REQ-029 On i_Rst=1 at a clock edge, the block SHALL:
- set state to SEARCH;
- set the prediction and the match and miss counters to 0;
- set o_Locked, o_Error, o_Lock_Lost, o_Error_Count and o_Word_Count to 0.
REQ-030 i_Rst SHALL take priority over i_Data_Valid and i_Clear_Counts.
REQ-031 Reset asserted mid-lock SHALL force SEARCH and SHALL NOT set o_Lock_Lost.

Configuration
REQ-032 Macro LFSR_CHECKER_WORD_COUNT_EN, when defined, SHALL compile in the o_Word_Count counter as specified above.
REQ-033 When LFSR_CHECKER_WORD_COUNT_EN is undefined, o_Word_Count SHALL be tied to 0, no counter logic SHALL be built, and all other behaviour SHALL be unchanged.

Verification
REQ-034 NUM_BITS=16, clean sequence from seed 0x0000 fed on consecutive valid cycles -> o_Locked=1 after the 5th word (first word seeds, 4 matches); o_Error_Count stays 0.
REQ-035 While locked, corrupt one word (XOR 0x0001) -> one o_Error pulse, o_Error_Count=1, lock held, next word matches.
REQ-036 While locked, corrupt 3 consecutive words -> o_Locked=0 after the 3rd, o_Lock_Lost=1, o_Error_Count=3; the clean stream then relocks after 4 matches.
REQ-037 Feed all-ones words plus a valid stream with 2-cycle valid gaps -> no lock from the all-ones words; the gapped stream locks identically to the ungapped stream.
REQ-038 Force o_Error_Count to 0xFFFFFFFF and inject an error -> the count holds at 0xFFFFFFFF.
REQ-039 i_Clear_Counts on the same cycle as an error -> the count reads 0.
REQ-040 Assert i_Rst while locked -> all outputs 0 on the next cycle and o_Lock_Lost=0.
REQ-041 Build with LFSR_CHECKER_WORD_COUNT_EN undefined -> o_Word_Count is constant 0.
